// File: rtl/cache_bus_pkg.sv
// Shared types and helpers for the cache line-fill bus arbiter.
// Holds the FSM state enum, requester indices and line offset math.
package cache_bus_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WRITE,
    S_READ,
    S_DONE
  } state_t;

  localparam int REQ_I = 0;
  localparam int REQ_D = 1;

  function automatic int line_off_bits(
    input int beats,
    input int dw
  );
    return $clog2(beats * dw / 8);
  endfunction

endpackage

// File: rtl/line_fill_arbiter_if.sv
// Requester and memory-bus signal bundle for the line-fill arbiter.
// master is the arbiter view; slave is the caches plus memory view.
interface line_fill_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [1:0]              req_valid;
  logic [1:0]              req_write;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [1:0]              req_ready;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              wdata_ready;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic [1:0]              resp_valid;
  logic                    resp_last;
  logic [1:0]              done;
  logic                    mem_avalid;
  logic                    mem_aready;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic                    mem_write;
  logic                    mem_wvalid;
  logic                    mem_wready;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_wlast;
  logic                    mem_rvalid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_wdata,
    input  mem_aready, mem_wready,
    input  mem_rvalid, mem_rdata,
    output req_ready, wdata_ready,
    output resp_data, resp_valid, resp_last,
    output done,
    output mem_avalid, mem_addr, mem_write,
    output mem_wvalid, mem_wdata, mem_wlast
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_wdata,
    output mem_aready, mem_wready,
    output mem_rvalid, mem_rdata,
    input  req_ready, wdata_ready,
    input  resp_data, resp_valid, resp_last,
    input  done,
    input  mem_avalid, mem_addr, mem_write,
    input  mem_wvalid, mem_wdata, mem_wlast
  );
endinterface

// File: rtl/line_fill_arbiter_rr_pick2.sv
// Two-requester round-robin picker, purely combinational.
// On a tie the requester that did not own the bus last wins.
module rr_pick2
  import cache_bus_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_owner,
  output logic       grant,
  output logic       gvalid
);

  assign gvalid = |valid;

  always_comb begin
    grant = 1'(REQ_I);
    if (valid[REQ_D] &&
        (!valid[REQ_I] || last_owner == 1'(REQ_I)))
      grant = 1'(REQ_D);
  end

endmodule

// File: rtl/line_fill_arbiter.sv
// Shares one memory bus between icache and dcache line transfers.
// One line request at a time: address phase, BEATS-beat burst, done.
module line_fill_arbiter
  import cache_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int BEATS      = 8
) (
  input logic               clk,
  input logic               reset,
  line_fill_arbiter_if.master bus
);

  localparam int CW  = $clog2(BEATS);
  localparam int OFF = line_off_bits(BEATS, DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    {ADDR_WIDTH{1'b1}} << OFF;
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  state_t                state;
  state_t                nstate;
  logic                  owner;
  logic                  wr;
  logic                  last_owner;
  logic [ADDR_WIDTH-1:0] addr;
  logic [CW-1:0]         cnt;
  logic                  grant;
  logic                  gvalid;
  logic [1:0]            own_oh;
  logic                  wbeat;
  logic                  rbeat;
  logic [ADDR_WIDTH-1:0] gaddr;

  rr_pick2 u_pick (
    .valid      (bus.req_valid),
    .last_owner (last_owner),
    .grant      (grant),
    .gvalid     (gvalid)
  );

  assign own_oh = owner ? 2'b10 : 2'b01;
  assign wbeat  = (state == S_WRITE) && bus.mem_wready;
  assign rbeat  = (state == S_READ) && bus.mem_rvalid;
  assign gaddr  = grant
    ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
    : bus.req_addr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_owner <= 1'b1;
      owner      <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        S_IDLE: begin
          if (gvalid) begin
            owner <= grant;
            wr    <= bus.req_write[grant];
            addr  <= gaddr & AMASK;
          end
        end
        S_ADDR: begin
          if (bus.mem_aready) cnt <= '0;
        end
        S_WRITE: begin
          if (wbeat) cnt <= cnt + CW'(1);
        end
        S_READ: begin
          if (rbeat) cnt <= cnt + CW'(1);
        end
        S_DONE: last_owner <= owner;
        default: ;
      endcase
    end
  end

  // Every output is decoded from state, so reset clears them at once.
  always_comb begin
    nstate          = state;
    bus.req_ready   = 2'b00;
    bus.wdata_ready = 2'b00;
    bus.resp_data   = '0;
    bus.resp_valid  = 2'b00;
    bus.resp_last   = 1'b0;
    bus.done        = 2'b00;
    bus.mem_avalid  = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_write   = 1'b0;
    bus.mem_wvalid  = 1'b0;
    bus.mem_wdata   = '0;
    bus.mem_wlast   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gvalid && !reset) begin
          bus.req_ready = grant ? 2'b10 : 2'b01;
          nstate        = S_ADDR;
        end
      end
      S_ADDR: begin
        bus.mem_avalid = 1'b1;
        bus.mem_addr   = addr;
        bus.mem_write  = wr;
        if (bus.mem_aready)
          nstate = wr ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        bus.mem_wvalid = 1'b1;
        bus.mem_wdata  = owner
          ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
          : bus.req_wdata[DATA_WIDTH-1:0];
        bus.wdata_ready =
          bus.mem_wready ? own_oh : 2'b00;
        bus.mem_wlast = (cnt == LAST);
        if (wbeat && cnt == LAST) nstate = S_DONE;
      end
      S_READ: begin
        bus.resp_data  = bus.mem_rdata;
        bus.resp_valid =
          bus.mem_rvalid ? own_oh : 2'b00;
        bus.resp_last  = rbeat && (cnt == LAST);
        if (rbeat && cnt == LAST) nstate = S_DONE;
      end
      S_DONE: begin
        bus.done = own_oh;
        nstate   = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter: vector table plus
// hand-written writeback, tie, stall and reset sequences.
module tb_line_fill_arbiter;
  import cache_bus_pkg::*;

  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int BEATS = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  line_fill_arbiter_if #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) bus ();

  line_fill_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BEATS(BEATS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  rv;
    logic        ar;
    logic        rvld;
    logic [63:0] rd;
    logic [12:0] eo;
    logic [63:0] ea;
    logic [63:0] ed;
  } vec_t;

  vec_t v[15];

  task automatic chk(
    input string        name,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.req_valid  = 2'b00;
    bus.req_write  = 2'b00;
    bus.req_wdata  = '0;
    bus.mem_aready = 1'b0;
    bus.mem_wready = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  function automatic logic [12:0] obs();
    return {bus.req_ready, bus.mem_avalid,
            bus.mem_write, bus.resp_valid,
            bus.resp_last, bus.done,
            bus.wdata_ready, bus.mem_wvalid,
            bus.mem_wlast};
  endfunction

  function automatic logic [12:0] mk(
    input logic [1:0] rdy,
    input logic       av,
    input logic       mw,
    input logic [1:0] rsp,
    input logic       last,
    input logic [1:0] dn,
    input logic [1:0] wrdy,
    input logic       wv,
    input logic       wl
  );
    return {rdy, av, mw, rsp, last, dn, wrdy, wv, wl};
  endfunction

  function automatic vec_t row(
    input logic [1:0]  rv,
    input logic        ar,
    input logic        rvld,
    input logic [63:0] rd,
    input logic [12:0] eo,
    input logic [63:0] ea,
    input logic [63:0] ed
  );
    vec_t r;
    r.rv = rv; r.ar = ar; r.rvld = rvld; r.rd = rd;
    r.eo = eo; r.ea = ea; r.ed = ed;
    return r;
  endfunction

  // Full refill for owner o at line address a, ADDR through DONE.
  task automatic run_read(
    input logic        o,
    input logic [63:0] a,
    input string       tag
  );
    logic [1:0] oh;
    oh = o ? 2'b10 : 2'b01;
    bus.mem_aready = 1'b1;
    @(negedge clk);
    chk({tag, "_avalid"}, 128'(bus.mem_avalid), 128'(1));
    chk({tag, "_addr"}, 128'(bus.mem_addr), 128'(a));
    step();
    bus.mem_aready = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'(k);
      @(negedge clk);
      chk($sformatf("%s_beat%0d", tag, k),
          128'({bus.resp_valid, bus.resp_last,
                bus.resp_data}),
          128'({oh, k == BEATS - 1, 64'(k)}));
      step();
    end
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    @(negedge clk);
    chk({tag, "_done"},
        128'({bus.done, bus.req_ready}),
        128'({oh, 2'b00}));
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int beat, pulses, lasts, dones;
    int wlast_bad, wdata_bad, leak;

    quiet();
    bus.req_addr = '0;
    reset = 1'b1;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("reset_outputs", 128'(obs()), 128'(0));
    step();
    reset = 1'b0;
    bus.req_valid = 2'b00;
    step();

    // Icache refill with spurious rvalid, aready stall and a gap.
    bus.req_addr[63:0] = 64'h1038;
    v[0] = row(2'b00, 0, 1, 64'h55, 13'h0, 0, 0);
    v[1] = row(2'b01, 0, 0, 0,
               mk(2'b01, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0);
    v[2] = row(2'b00, 0, 1, 64'h77,
               mk(0, 1, 0, 0, 0, 0, 0, 0, 0),
               64'h1000, 0);
    v[3] = row(2'b00, 1, 0, 0,
               mk(0, 1, 0, 0, 0, 0, 0, 0, 0),
               64'h1000, 0);
    for (int k = 0; k < 3; k++)
      v[4 + k] = row(2'b00, 0, 1, 64'(k),
                     mk(0, 0, 0, 2'b01, 0, 0, 0, 0, 0),
                     0, 64'(k));
    v[7] = row(2'b00, 0, 0, 0, 13'h0, 0, 0);
    for (int k = 3; k < 8; k++)
      v[5 + k] = row(2'b00, 0, 1, 64'(k),
                     mk(0, 0, 0, 2'b01, k == 7,
                        0, 0, 0, 0),
                     0, 64'(k));
    v[13] = row(2'b00, 0, 0, 0,
                mk(0, 0, 0, 0, 0, 2'b01, 0, 0, 0), 0, 0);
    v[14] = row(2'b00, 0, 1, 64'h9, 13'h0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      bus.req_valid  = v[i].rv;
      bus.mem_aready = v[i].ar;
      bus.mem_rvalid = v[i].rvld;
      bus.mem_rdata  = v[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d_ctl", i),
          128'(obs()), 128'(v[i].eo));
      chk($sformatf("vec%0d_addr", i),
          128'(bus.mem_addr), 128'(v[i].ea));
      chk($sformatf("vec%0d_data", i),
          128'(bus.resp_data), 128'(v[i].ed));
      step();
    end
    quiet();

    // Dcache writeback with a 5-cycle address stall.
    bus.req_addr[127:64] = 64'h2040;
    bus.req_valid = 2'b10;
    bus.req_write = 2'b10;
    @(negedge clk);
    chk("wb_ready", 128'(bus.req_ready), 128'(2'b10));
    step();
    bus.req_valid = 2'b00;
    bus.req_write = 2'b00;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      chk($sformatf("stall%0d", s),
          128'({bus.mem_avalid, bus.mem_write,
                bus.mem_addr, bus.mem_wvalid,
                bus.wdata_ready, bus.resp_valid}),
          128'({2'b11, 64'h2040, 5'b0}));
      step();
    end
    bus.mem_aready = 1'b1;
    @(negedge clk);
    chk("wb_aphase", 128'({bus.mem_avalid,
                           bus.mem_addr}),
        128'({1'b1, 64'h2040}));
    step();
    bus.mem_aready = 1'b0;

    beat = 0; pulses = 0; lasts = 0; dones = 0;
    wlast_bad = 0; wdata_bad = 0; leak = 0;
    for (int t = 0; t < 40; t++) begin
      bus.mem_wready = t[0];
      bus.req_wdata[127:64] = 64'hA000 + 64'(beat);
      @(negedge clk);
      if (bus.wdata_ready[1]) begin
        pulses++;
        if (bus.mem_wlast) lasts++;
        if (bus.mem_wlast != (pulses == 8))
          wlast_bad++;
        if (bus.mem_wdata != 64'hA000 + 64'(beat))
          wdata_bad++;
        beat++;
      end
      if (bus.wdata_ready[0] || bus.resp_valid != 0)
        leak++;
      if (bus.done[1]) dones++;
      step();
    end
    quiet();
    chk("wb_pulses", 128'(pulses), 128'(8));
    chk("wb_lasts", 128'(lasts), 128'(1));
    chk("wb_wlast_pos", 128'(wlast_bad), 128'(0));
    chk("wb_wdata", 128'(wdata_bad), 128'(0));
    chk("wb_leak", 128'(leak), 128'(0));
    chk("wb_done", 128'(dones), 128'(1));

    // Ties: icache first after reset, then alternating.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    bus.req_addr[63:0]   = 64'h3008;
    bus.req_addr[127:64] = 64'h4010;
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("tie1", 128'(bus.req_ready), 128'(2'b01));
    step();
    bus.req_valid = 2'b10;
    run_read(1'b0, 64'h3000, "tie1_i");
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("tie2", 128'(bus.req_ready), 128'(2'b10));
    step();
    bus.req_valid = 2'b01;
    run_read(1'b1, 64'h4000, "tie2_d");
    bus.req_valid = 2'b11;
    @(negedge clk);
    chk("tie3", 128'(bus.req_ready), 128'(2'b01));
    step();
    bus.req_valid = 2'b00;
    run_read(1'b0, 64'h3000, "tie3_i");

    // Reset mid-refill after beat 3, then a clean refill.
    bus.req_addr[63:0] = 64'h1038;
    bus.req_valid = 2'b01;
    step();
    bus.req_valid  = 2'b00;
    bus.mem_aready = 1'b1;
    step();
    bus.mem_aready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 64'(k);
      step();
    end
    bus.mem_rdata = 64'h4;
    bus.req_valid = 2'b01;
    reset = 1'b1;
    #1;
    chk("mid_reset_ctl", 128'(obs()), 128'(0));
    chk("mid_reset_bus",
        128'({bus.resp_data, bus.mem_addr}), 128'(0));
    step();
    quiet();
    step();
    reset = 1'b0;
    bus.req_valid = 2'b01;
    @(negedge clk);
    chk("post_reset_rdy", 128'(bus.req_ready),
        128'(2'b01));
    step();
    bus.req_valid = 2'b00;
    run_read(1'b0, 64'h1000, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
